// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared widths and state encodings for the slew-limited PWM duty sequencer.
package pwm_duty_sequencer_pkg;

    localparam int PWM_WIDTH       = 16;
    localparam int PWM_PERIOD_BITS = 16;
    // Divider counter width; covers DIV_PERIODS in 1..255.
    localparam int DIV_BITS        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_STOP = 2'd3
    } state_e;

endpackage

// File: rtl/pwm_duty_sequencer_timer.sv
// Free-running PWM period counter plus period-boundary divider.
// Period_tick is high on the last clock of every period; upd_tick is high on the
// last clock of every DIV_PERIODS-th period. Both are registered, pre-decoded
// from the next count, so they line up exactly with cnt == all-ones.
module pwm_duty_sequencer_timer
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int PERIOD_BITS = PWM_PERIOD_BITS,
    parameter int DIV_PERIODS = 1
) (
    input  logic Clk,
    input  logic Rst_n,
    output logic Period_tick,
    output logic upd_tick
);

    localparam logic [PERIOD_BITS-1:0] CNT_LAST = {PERIOD_BITS{1'b1}};
    localparam logic [DIV_BITS-1:0]    DIV_LAST = DIV_BITS'(DIV_PERIODS - 1);

    logic [PERIOD_BITS-1:0] cnt_r;
    logic [PERIOD_BITS-1:0] cnt_nxt_s;
    logic [DIV_BITS-1:0]    div_r;
    logic                   tick_r;
    logic                   upd_r;

    // Next value of the period counter; wraps all-ones -> 0 naturally
    always_comb begin
        cnt_nxt_s = cnt_r + PERIOD_BITS'(1'b1);
    end

    // Period counter, divider and registered tick flags
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_r  <= {PERIOD_BITS{1'b0}};
            div_r  <= {DIV_BITS{1'b0}};
            tick_r <= 1'b0;
            upd_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_LAST);
            // div_r is stable until the tick edge, so it can be sampled one clock early
            upd_r  <= (cnt_nxt_s == CNT_LAST) && (div_r == DIV_LAST);
            if (tick_r) begin
                if (div_r == DIV_LAST) begin
                    div_r <= {DIV_BITS{1'b0}};
                end else begin
                    div_r <= div_r + 8'd1;
                end
            end else begin
                div_r <= div_r;
            end
        end
    end

    assign Period_tick = tick_r;
    assign upd_tick    = upd_r;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Slew-rate-limited duty scheduler feeding a PWM compare input.
// Targets arrive over valid/ready; the live duty steps toward the target by at
// most Step, and only on update-tick edges so the new compare value becomes live
// exactly at ramp count 0. Stop forces duty to 0 on the next clock.
module pwm_duty_sequencer
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int PERIOD_BITS = PWM_PERIOD_BITS,
    parameter int DIV_PERIODS = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Enable,
    input  logic             Stop,
    input  logic [WIDTH-1:0] Tgt_duty,
    input  logic             Tgt_valid,
    output logic             Tgt_ready,
    input  logic [WIDTH-1:0] Step,
    output logic [WIDTH-1:0] Duty_out,
    output logic             Period_tick,
    output logic             At_target,
    output logic             Busy
);

    localparam logic [WIDTH-1:0] DUTY_ZERO = {WIDTH{1'b0}};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] duty_r;
    logic [WIDTH-1:0] duty_nxt_s;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] target_nxt_s;
    logic             at_target_r;
    logic             busy_r;
    logic             upd_tick_s;
    logic             ready_s;
    logic             accept_s;
    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   floor_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] slew_s;

    pwm_duty_sequencer_timer #(
        .PERIOD_BITS (PERIOD_BITS),
        .DIV_PERIODS (DIV_PERIODS)
    ) u_timer (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Period_tick (Period_tick),
        .upd_tick    (upd_tick_s)
    );

    // Handshake: ready is combinational so a target can land in the same cycle
    always_comb begin
        ready_s  = Enable & ~Stop & (state_r != ST_STOP);
        accept_s = Tgt_valid & ready_s;
    end

    assign Tgt_ready = ready_s;

    // Saturating slew toward the registered (old) target, in WIDTH+1 bits so nothing wraps
    always_comb begin
        step_ext_s = (Step == DUTY_ZERO) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, Step};
        sum_s      = {1'b0, duty_r} + step_ext_s;
        floor_s    = {1'b0, target_r} + step_ext_s;
        diff_s     = {1'b0, duty_r} - step_ext_s;
        if (duty_r < target_r) begin
            if (sum_s > {1'b0, target_r}) begin
                slew_s = target_r;
            end else begin
                slew_s = sum_s[WIDTH-1:0];
            end
        end else if (duty_r > target_r) begin
            if ({1'b0, duty_r} >= floor_s) begin
                slew_s = diff_s[WIDTH-1:0];
            end else begin
                slew_s = target_r;
            end
        end else begin
            slew_s = duty_r;
        end
    end

    // Next-state logic: Stop > Enable-fall > target accept > slew
    always_comb begin
        state_nxt_s  = state_r;
        duty_nxt_s   = duty_r;
        target_nxt_s = target_r;
        if (Stop) begin
            state_nxt_s  = ST_STOP;
            duty_nxt_s   = DUTY_ZERO;
            target_nxt_s = DUTY_ZERO;
        end else begin
            case (state_r)
                ST_STOP: begin
                    state_nxt_s  = ST_IDLE;
                    duty_nxt_s   = DUTY_ZERO;
                    target_nxt_s = DUTY_ZERO;
                end
                ST_IDLE: begin
                    duty_nxt_s = DUTY_ZERO;
                    if (accept_s) begin
                        target_nxt_s = Tgt_duty;
                    end else begin
                        target_nxt_s = target_r;
                    end
                    if (Enable && (target_nxt_s != DUTY_ZERO)) begin
                        state_nxt_s = ST_RAMP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RAMP, ST_HOLD: begin
                    if (!Enable) begin
                        target_nxt_s = DUTY_ZERO;
                    end else if (accept_s) begin
                        target_nxt_s = Tgt_duty;
                    end else begin
                        target_nxt_s = target_r;
                    end
                    if ((state_r == ST_RAMP) && upd_tick_s) begin
                        duty_nxt_s = slew_s;
                    end else begin
                        duty_nxt_s = duty_r;
                    end
                    if (!Enable && (target_r == DUTY_ZERO) && (duty_r == DUTY_ZERO)) begin
                        state_nxt_s = ST_IDLE;
                    end else if (!Enable) begin
                        state_nxt_s = ST_RAMP;
                    end else if (target_nxt_s != duty_r) begin
                        state_nxt_s = ST_RAMP;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    duty_nxt_s   = DUTY_ZERO;
                    target_nxt_s = DUTY_ZERO;
                end
            endcase
        end
    end

    // State, duty, target and registered status flags
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= ST_IDLE;
            duty_r      <= DUTY_ZERO;
            target_r    <= DUTY_ZERO;
            at_target_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            duty_r      <= duty_nxt_s;
            target_r    <= target_nxt_s;
            at_target_r <= (duty_nxt_s == target_nxt_s);
            busy_r      <= (state_nxt_s == ST_RAMP);
        end
    end

    assign Duty_out  = duty_r;
    assign At_target = at_target_r;
    assign Busy      = busy_r;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with a 16-clock PWM period.
module tb_pwm_duty_sequencer;

    localparam int PB = 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Enable;
    logic        Stop;
    logic [15:0] Tgt_duty;
    logic        Tgt_valid;
    logic        Tgt_ready;
    logic [15:0] Step;
    logic [15:0] Duty_out;
    logic        Period_tick;
    logic        At_target;
    logic        Busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PB-1:0] tb_cnt;

    pwm_duty_sequencer #(
        .WIDTH       (16),
        .PERIOD_BITS (PB),
        .DIV_PERIODS (1)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Enable      (Enable),
        .Stop        (Stop),
        .Tgt_duty    (Tgt_duty),
        .Tgt_valid   (Tgt_valid),
        .Tgt_ready   (Tgt_ready),
        .Step        (Step),
        .Duty_out    (Duty_out),
        .Period_tick (Period_tick),
        .At_target   (At_target),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    // Reference ramp position: counts clocks since reset release
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 1'b1;
    end

    typedef struct {
        logic        en;
        logic [15:0] tgt;
        logic        vld;
        logic [15:0] step;
        logic        per;     // 1: run to next period start, 0: one clock
        logic [15:0] e_duty;
        logic        e_at;
        logic        e_busy;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic adv_period(input string nm);
        int k;
        k = 0;
        @(negedge Clk);
        while (!Period_tick && k < 64) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 64) check({nm, "_tick_timeout"}, 32'd0, 32'd1);
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_duty;
        int bad_tick;
        int ticks;
        int n;
        logic [15:0] prev;

        //              en    tgt       vld   step      per   duty      at    busy  rdy
        vecs[0]  = '{1'b1, 16'h4000, 1'b1, 16'h1000, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 16'h4000, 1'b1, 16'h1000, 1'b1, 16'h2000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 16'h4000, 1'b1, 16'h1000, 1'b1, 16'h3000, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 16'h4000, 1'b1, 16'h1000, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 16'h4000, 1'b1, 16'h1000, 1'b0, 16'h4000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'hFF00, 1'b1, 16'hC000, 1'b1, 16'hFF00, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 16'hFFFF, 1'b1, 16'h1000, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 16'hFFFF, 1'b1, 16'h1000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 16'h0100, 1'b1, 16'hFFFF, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0300, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 16'h0300, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h0003, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 16'h0003, 1'b1, 16'h0000, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 16'h0003, 1'b1, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 16'h0003, 1'b1, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 16'h1000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};

        // Reset state
        Rst_n = 1'b0; Enable = 1'b0; Stop = 1'b0;
        Tgt_duty = 16'h0000; Tgt_valid = 1'b0; Step = 16'h0000;
        repeat (3) @(negedge Clk);
        check("reset_duty", {16'h0, Duty_out}, 32'h0);
        check("reset_at_target", {31'h0, At_target}, 32'h1);
        check("reset_busy", {31'h0, Busy}, 32'h0);
        check("reset_tick", {31'h0, Period_tick}, 32'h0);
        check("reset_ready", {31'h0, Tgt_ready}, 32'h0);
        Rst_n = 1'b1;

        // Table-driven vectors: ramp up, saturation at both ends, step 0, Enable fall
        for (int i = 0; i < 17; i++) begin
            Enable    = vecs[i].en;
            Tgt_duty  = vecs[i].tgt;
            Tgt_valid = vecs[i].vld;
            Step      = vecs[i].step;
            if (vecs[i].per) adv_period($sformatf("vec%0d", i));
            else             @(negedge Clk);
            check($sformatf("vec%0d_duty", i), {16'h0, Duty_out}, {16'h0, vecs[i].e_duty});
            check($sformatf("vec%0d_at_target", i), {31'h0, At_target}, {31'h0, vecs[i].e_at});
            check($sformatf("vec%0d_busy", i), {31'h0, Busy}, {31'h0, vecs[i].e_busy});
            check($sformatf("vec%0d_ready", i), {31'h0, Tgt_ready}, {31'h0, vecs[i].e_rdy});
        end

        // Stop pulsed mid-ramp at duty 0x3000
        Enable = 1'b1; Tgt_duty = 16'h8000; Tgt_valid = 1'b1; Step = 16'h1000;
        repeat (3) adv_period("stop_setup");
        check("stop_pre_duty", {16'h0, Duty_out}, 32'h3000);
        repeat (5) @(negedge Clk);
        Stop = 1'b1;
        #1;
        check("stop_ready_low", {31'h0, Tgt_ready}, 32'h0);
        @(negedge Clk);
        check("stop_duty_zero", {16'h0, Duty_out}, 32'h0);
        check("stop_busy", {31'h0, Busy}, 32'h0);
        check("stop_at_target", {31'h0, At_target}, 32'h1);
        repeat (2) @(negedge Clk);
        check("stop_held_duty", {16'h0, Duty_out}, 32'h0);
        check("stop_held_ready", {31'h0, Tgt_ready}, 32'h0);
        Stop = 1'b0;
        #1;
        check("stop_release_ready", {31'h0, Tgt_ready}, 32'h0);
        @(negedge Clk);
        check("idle_after_stop_ready", {31'h0, Tgt_ready}, 32'h1);
        check("idle_after_stop_duty", {16'h0, Duty_out}, 32'h0);

        // Target held valid across boundaries: duty moves only into ramp cnt 0
        bad_duty = 0; bad_tick = 0; ticks = 0;
        prev = Duty_out;
        for (int c = 0; c < 48; c++) begin
            @(negedge Clk);
            if (Duty_out !== prev && tb_cnt != '0) bad_duty++;
            if (Period_tick !== (tb_cnt == {PB{1'b1}})) bad_tick++;
            if (Period_tick) ticks++;
            prev = Duty_out;
        end
        check("hold_valid_duty_midperiod", bad_duty, 0);
        check("hold_valid_tick_alignment", bad_tick, 0);
        check("hold_valid_tick_count", ticks, 3);

        n = 0;
        while (!(Busy === 1'b0 && Duty_out === 16'h8000) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check("reach_hold_duty", {16'h0, Duty_out}, 32'h8000);
        check("reach_hold_busy", {31'h0, Busy}, 32'h0);

        // Reset mid-HOLD: asynchronous clear, counter restarts
        n = 0;
        while (tb_cnt != 4'd5 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        #2 Rst_n = 1'b0;
        #1;
        check("async_rst_duty", {16'h0, Duty_out}, 32'h0);
        check("async_rst_busy", {31'h0, Busy}, 32'h0);
        check("async_rst_at_target", {31'h0, At_target}, 32'h1);
        check("async_rst_tick", {31'h0, Period_tick}, 32'h0);
        Enable = 1'b0; Tgt_valid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        n = 0;
        while (!Period_tick && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("restart_tick_delay", n, 15);
        check("restart_duty", {16'h0, Duty_out}, 32'h0);
        check("restart_busy", {31'h0, Busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
